spi_reg_bridge: RTL and testbench

MCU-facing SPI target that drives the cart core's register-write port (`wr_reg`, `wr_reg_addr`, `wr_reg_changed`) and returns the loader status word (`loader_out`) on read. It sits between the MCU SPI pins and the mapper multiplexer. The multiplexer samples the toggle on the slow NES M2 domain, so this block paces commits with a hold window and keeps one pending write in a buffer.

---
 rtl/spi_reg_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target that paces register commits to the cart core and returns the loader status word.
// Optional readback path is built only when SPI_REG_READBACK_EN is defined.
module spi_reg_bridge #(
  parameter int HOLD_CYCLES = 64,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [31:0]       wr_reg,
  output logic [ADDR_W-1:0] wr_reg_addr,
  output logic              wr_reg_changed,
  input  logic [31:0]       rd_data,
  output logic              overrun
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD,
    ST_IGNORE,
    ST_DONE
  } state_t;

  logic [2:0] r_sckSync;
  logic [2:0] r_csSync;
  logic [1:0] r_mosiSync;

  // cs resets high so releasing reset with the bus idle produces no false edge
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_sckSync  <= 3'b000;
      r_csSync   <= 3'b111;
      r_mosiSync <= 2'b00;
    end else begin
      r_sckSync  <= {r_sckSync[1:0], spi_sck};
      r_csSync   <= {r_csSync[1:0], spi_cs_n};
      r_mosiSync <= {r_mosiSync[0], spi_mosi};
    end
  end

  logic w_sckRise;
  logic w_sckFall;
  logic w_csFall;
  logic w_csRise;
  logic w_mosi;

  assign w_sckRise = r_sckSync[1] & ~r_sckSync[2];
  assign w_sckFall = ~r_sckSync[1] & r_sckSync[2];
  assign w_csFall  = ~r_csSync[1] & r_csSync[2];
  assign w_csRise  = r_csSync[1] & ~r_csSync[2];
  assign w_mosi    = r_mosiSync[1];

  state_t      r_state;
  state_t      w_nextState;
  logic [5:0]  r_bitCnt;
  logic [6:0]  r_cmd;
  logic [31:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic        r_offerValid;
  logic [31:0] r_offerData;
  logic [ADDR_W-1:0] r_offerAddr;

  logic [7:0] w_cmdByte;
  logic       w_lastCmdBit;
  logic       w_lastDataBit;
  logic       w_cmdValid;

  assign w_cmdByte     = {r_cmd, w_mosi};
  assign w_lastCmdBit  = w_sckRise && (r_bitCnt == 6'd7);
  assign w_lastDataBit = w_sckRise && (r_bitCnt == 6'd39);
  assign w_cmdValid    = (w_cmdByte[6:4] == 3'b000);

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) r_state <= ST_IDLE;
    else             r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_csRise) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_csFall) w_nextState = ST_CMD;
        ST_CMD: begin
          if (w_lastCmdBit) begin
            if (!w_cmdValid)
              w_nextState = ST_IGNORE;
            else if (w_cmdByte[7])
`ifdef SPI_REG_READBACK_EN
              w_nextState = ST_RD;
`else
              w_nextState = ST_IGNORE;
`endif
            else
              w_nextState = ST_WR;
          end
        end
        ST_WR, ST_RD: if (w_lastDataBit) w_nextState = ST_DONE;
        default: w_nextState = r_state;
      endcase
    end
  end

  logic w_offer;
  logic w_shiftIn;
  logic w_rdLoad;
  logic w_rdShift;

  always_comb begin
    w_offer   = (r_state == ST_WR) && w_lastDataBit && !w_csRise;
    w_shiftIn = w_sckRise && ((r_state == ST_CMD) || (r_state == ST_WR) || (r_state == ST_RD));
    w_rdLoad  = (r_state == ST_CMD) && (w_nextState == ST_RD);
    w_rdShift = (r_state == ST_RD) && w_sckFall;
  end

  // Frame datapath; the completed {addr, data} word is registered as a one-cycle offer
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_bitCnt     <= '0;
      r_cmd        <= '0;
      r_data       <= '0;
      r_addr       <= '0;
      r_offerValid <= 1'b0;
      r_offerData  <= '0;
      r_offerAddr  <= '0;
    end else begin
      r_offerValid <= w_offer;
      if (w_offer) begin
        r_offerData <= {r_data[30:0], w_mosi};
        r_offerAddr <= r_addr;
      end
      if (w_csFall)       r_bitCnt <= '0;
      else if (w_shiftIn) r_bitCnt <= r_bitCnt + 6'd1;
      if (w_shiftIn) begin
        if (r_state == ST_CMD) r_cmd  <= w_cmdByte[6:0];
        else                   r_data <= {r_data[30:0], w_mosi};
      end
      if ((r_state == ST_CMD) && w_lastCmdBit) r_addr <= w_cmdByte[ADDR_W-1:0];
    end
  end

`ifdef SPI_REG_READBACK_EN
  logic [31:0] r_rdShift;
  logic        r_miso;

  // Zeros shift in behind the snapshot, so miso falls to 0 once all 32 bits are out
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_rdShift <= '0;
      r_miso    <= 1'b0;
    end else if (w_rdLoad) begin
      r_rdShift <= rd_data;
    end else if (w_rdShift) begin
      r_miso    <= r_rdShift[31];
      r_rdShift <= {r_rdShift[30:0], 1'b0};
    end else if (w_sckFall || w_csRise) begin
      r_miso    <= 1'b0;
    end
  end

  assign spi_miso = r_miso;
`else
  logic w_unusedRd;
  assign w_unusedRd = ^{rd_data, w_sckFall, w_rdLoad, w_rdShift};
  assign spi_miso   = 1'b0;
`endif

  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_pendValid;
  logic [31:0]       r_pendData;
  logic [ADDR_W-1:0] r_pendAddr;
  logic [31:0]       r_wrReg;
  logic [ADDR_W-1:0] r_wrAddr;
  logic              r_changed;
  logic              r_overrun;
  logic              w_holdZero;

  assign w_holdZero = (r_holdCnt == '0);

  // Commit stage: pending entry has priority over a fresh offer, which then takes the buffer
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_holdCnt   <= '0;
      r_pendValid <= 1'b0;
      r_pendData  <= '0;
      r_pendAddr  <= '0;
      r_wrReg     <= '0;
      r_wrAddr    <= '0;
      r_changed   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (!w_holdZero) r_holdCnt <= r_holdCnt - HOLD_W'(1);
      if (w_holdZero && r_pendValid) begin
        r_wrReg     <= r_pendData;
        r_wrAddr    <= r_pendAddr;
        r_changed   <= ~r_changed;
        r_holdCnt   <= HOLD_RELOAD;
        r_pendValid <= r_offerValid;
        if (r_offerValid) begin
          r_pendData <= r_offerData;
          r_pendAddr <= r_offerAddr;
        end
      end else if (w_holdZero && r_offerValid) begin
        r_wrReg   <= r_offerData;
        r_wrAddr  <= r_offerAddr;
        r_changed <= ~r_changed;
        r_holdCnt <= HOLD_RELOAD;
      end else if (r_offerValid) begin
        if (r_pendValid) begin
          r_overrun <= 1'b1;
        end else begin
          r_pendValid <= 1'b1;
          r_pendData  <= r_offerData;
          r_pendAddr  <= r_offerAddr;
        end
      end
    end
  end

  assign wr_reg         = r_wrReg;
  assign wr_reg_addr    = r_wrAddr;
  assign wr_reg_changed = r_changed;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge: writes, aborts, pacing/overrun, ignore, readback, reset.
// Readback expectations follow SPI_REG_READBACK_EN when it is defined for the build.
module tb_spi_reg_bridge;

  localparam int HOLD = 600;

  logic        clk = 1'b0;
  logic        async_reset;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [31:0] wr_reg;
  logic [3:0]  wr_reg_addr;
  logic        wr_reg_changed;
  logic [31:0] rd_data;
  logic        overrun;

  spi_reg_bridge #(.HOLD_CYCLES(HOLD), .ADDR_W(4)) dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .spi_sck        (spi_sck),
    .spi_cs_n       (spi_cs_n),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .wr_reg         (wr_reg),
    .wr_reg_addr    (wr_reg_addr),
    .wr_reg_changed (wr_reg_changed),
    .rd_data        (rd_data),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Toggle monitor samples just after each active edge
  logic lastChg = 1'b0;
  int   toggleCount = 0;
  int   toggleCyc[$];
  always @(posedge clk) begin
    #1;
    if (!async_reset && (wr_reg_changed !== lastChg)) begin
      toggleCount = toggleCount + 1;
      toggleCyc.push_back(cyc);
    end
    lastChg = wr_reg_changed;
  end

  int total = 0;
  int bad = 0;
  int lastRiseCyc = 0;
  int lat;
  int tA;
  int cnt0;
  logic [31:0] rdback;
  logic [31:0] expRead;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic spiBit(input logic b, output logic sampled);
    spi_mosi = b;
    @(negedge clk);
    sampled = spi_miso;
    spi_sck = 1'b1;
    lastRiseCyc = cyc;
    @(negedge clk);
    @(negedge clk);
    spi_sck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                               input logic [31:0] newRd, output logic [31:0] rdOut);
    logic b;
    logic s;
    rdOut = '0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == 8) rd_data = newRd;
      b = (i < 8) ? cmd[7-i] : data[39-i];
      spiBit(b, s);
      if (i >= 8) rdOut[39-i] = s;
    end
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    async_reset = 1'b1;
    spi_sck     = 1'b0;
    spi_cs_n    = 1'b1;
    spi_mosi    = 1'b0;
    rd_data     = 32'h0;
    repeat (4) @(negedge clk);
    checkOutput("rst_wr_reg", wr_reg, 32'h0);
    checkOutput("rst_addr", {28'h0, wr_reg_addr}, 32'h0);
    checkOutput("rst_changed", {31'h0, wr_reg_changed}, 32'h0);
    checkOutput("rst_miso", {31'h0, spi_miso}, 32'h0);
    checkOutput("rst_overrun", {31'h0, overrun}, 32'h0);
    async_reset = 1'b0;
    repeat (4) @(negedge clk);

    applyStimulus(8'h01, 32'hDEADBEEF, 40, 32'h0, rdback);
    checkOutput("wr1_data", wr_reg, 32'hDEADBEEF);
    checkOutput("wr1_addr", {28'h0, wr_reg_addr}, 32'h1);
    checkOutput("wr1_changed", {31'h0, wr_reg_changed}, 32'h1);
    checkOutput("wr1_overrun", {31'h0, overrun}, 32'h0);
    checkOutput("wr1_toggles", toggleCount, 32'd1);
    lat = (toggleCyc.size() > 0) ? (toggleCyc[$] - lastRiseCyc) : -1;
    checkOutput("wr1_latency_le4", {31'h0, (lat >= 1 && lat <= 4)}, 32'h1);

    applyStimulus(8'h00, 32'hCAFEF00D, 20, 32'h0, rdback);
    checkOutput("abort_data", wr_reg, 32'hDEADBEEF);
    checkOutput("abort_addr", {28'h0, wr_reg_addr}, 32'h1);
    checkOutput("abort_toggles", toggleCount, 32'd1);
    repeat (HOLD) @(negedge clk);
    applyStimulus(8'h00, 32'h12345678, 40, 32'h0, rdback);
    checkOutput("wr2_data", wr_reg, 32'h12345678);
    checkOutput("wr2_addr", {28'h0, wr_reg_addr}, 32'h0);
    checkOutput("wr2_changed", {31'h0, wr_reg_changed}, 32'h0);
    checkOutput("wr2_toggles", toggleCount, 32'd2);

    applyStimulus(8'h71, 32'h0F0F0F0F, 40, 32'h0, rdback);
    repeat (HOLD + 50) @(negedge clk);
    checkOutput("inv_data", wr_reg, 32'h12345678);
    checkOutput("inv_addr", {28'h0, wr_reg_addr}, 32'h0);
    checkOutput("inv_toggles", toggleCount, 32'd2);
    checkOutput("inv_overrun", {31'h0, overrun}, 32'h0);

    applyStimulus(8'h02, 32'hAAAA0001, 40, 32'h0, rdback);
    checkOutput("b2b_a_data", wr_reg, 32'hAAAA0001);
    tA = (toggleCyc.size() > 0) ? toggleCyc[$] : 0;
    applyStimulus(8'h03, 32'hBBBB0002, 40, 32'h0, rdback);
    applyStimulus(8'h04, 32'hCCCC0003, 40, 32'h0, rdback);
    checkOutput("b2b_hold_data", wr_reg, 32'hAAAA0001);
    checkOutput("b2b_overrun", {31'h0, overrun}, 32'h1);
    repeat (120) @(negedge clk);
    checkOutput("b2b_b_data", wr_reg, 32'hBBBB0002);
    checkOutput("b2b_b_addr", {28'h0, wr_reg_addr}, 32'h3);
    checkOutput("b2b_spacing", (toggleCyc.size() > 0) ? (toggleCyc[$] - tA) : -1, HOLD);
    repeat (HOLD + 100) @(negedge clk);
    checkOutput("b2b_toggles", toggleCount, 32'd4);
    checkOutput("b2b_final_data", wr_reg, 32'hBBBB0002);

    rd_data = 32'h000000A5;
`ifdef SPI_REG_READBACK_EN
    expRead = 32'h000000A5;
`else
    expRead = 32'h0;
`endif
    applyStimulus(8'h81, 32'h0, 40, 32'hFFFF0000, rdback);
    checkOutput("rd_shifted", rdback, expRead);
    checkOutput("rd_miso_idle", {31'h0, spi_miso}, 32'h0);
    checkOutput("rd_toggles", toggleCount, 32'd4);
    checkOutput("rd_wr_reg", wr_reg, 32'hBBBB0002);

    applyStimulus(8'h05, 32'h55667788, 40, 32'h0, rdback);
    checkOutput("pre_rst_data", wr_reg, 32'h55667788);
    applyStimulus(8'h06, 32'h99AABBCC, 40, 32'h0, rdback);
    checkOutput("pre_rst_pending", wr_reg, 32'h55667788);
    repeat (10) @(negedge clk);
    async_reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mrst_wr_reg", wr_reg, 32'h0);
    checkOutput("mrst_addr", {28'h0, wr_reg_addr}, 32'h0);
    checkOutput("mrst_changed", {31'h0, wr_reg_changed}, 32'h0);
    checkOutput("mrst_miso", {31'h0, spi_miso}, 32'h0);
    checkOutput("mrst_overrun", {31'h0, overrun}, 32'h0);
    async_reset = 1'b0;
    @(negedge clk);
    cnt0 = toggleCount;
    repeat (HOLD + 100) @(negedge clk);
    checkOutput("post_rst_toggles", toggleCount, cnt0);
    checkOutput("post_rst_wr_reg", wr_reg, 32'h0);
    checkOutput("post_rst_changed", {31'h0, wr_reg_changed}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
